block_data_memory: RTL and testbench
====================================

# block_data_memory

Backing data memory that responds to the data cache's block-transfer requests on the memory side of the cache. It holds 64 blocks of 128 bits each (1 KiB), addressed by block index. It services one read-block or write-block request at a time with a programmable multi-cycle latency. It signals completion by dropping `mem_busywait`, which is the handshake the cache controller waits on before filling a line or finishing a write-back.

## Interface
- `LATENCY`, 5: clock edges from request acceptance to access completion (≥1).
- `ADDR_WIDTH`, 6: block-address width; depth = 2^ADDR_WIDTH blocks.
- `BLOCK_WIDTH`, 128: block width in bits (four 32-bit words, word 0 in bits [31:0]).
- `clock`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `mem_read`  in  1  block read request, held by requester until it sees busywait low.
- `mem_write`  in  1  block write request, same holding rule.
- `mem_address`  in  ADDR_WIDTH  block index.
- `mem_writedata`  in  BLOCK_WIDTH  block to store on write.
- `mem_readdata`  out  BLOCK_WIDTH  registered block returned by the last completed read.
- `mem_busywait`  out  1  high while a request is pending or in service.
- `protocol_error`  out  1  sticky flag: read and write asserted together at acceptance.

## Operation
- Storage is a 2^ADDR_WIDTH × BLOCK_WIDTH array. Reset clears all entries to 0.
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - `mem_busywait` = `mem_read | mem_write`, combinational, so the requester sees busywait in the same cycle it raises a request.
  - At a rising edge with a request present: latch address, write data, and op into internal registers. Load counter = LATENCY−1 and go to BUSY.
- BUSY:
  - `mem_busywait` = 1.
  - Input changes are ignored; only the latched values are used.
  - Each edge with counter ≠ 0 decrements the counter.
  - At the edge with counter = 0, perform the access and go to DONE:
    - write: array[addr] ← latched data;
    - read: `mem_readdata` ← array[addr].
- DONE:
  - `mem_busywait` = 0 for exactly one cycle and requests are ignored. The requester must deassert `mem_read`/`mem_write` in this cycle.
  - The next edge always returns to IDLE. A request still present in IDLE is treated as a new transaction.
- Simultaneous read and write at acceptance: the write is performed, `protocol_error` is set, and it holds until reset.
- `mem_readdata` is unchanged by writes. It changes only at read completion or reset.
- Reset mid-transaction aborts the transaction: no array update, FSM goes to IDLE, counter is cleared.

## Timing
- Reset values:
  - `mem_readdata` = 0, `protocol_error` = 0, state = IDLE, counter = 0.
  - `mem_busywait` = 0 while reset is high, regardless of the request inputs.
- Let E0 be the edge at which a request is accepted in IDLE:
  - the access takes effect at edge E0+LATENCY;
  - `mem_busywait` is high from request assertion through E0+LATENCY and low in the cycle that follows (DONE).
- With LATENCY=1, entry into BUSY sees counter=0 and the access occurs at E0+1.
- Read data is valid from E0+LATENCY until the next read completes.
- Back-to-back requests: the minimum spacing between accept edges is LATENCY+2 (accept, LATENCY edges to completion, DONE edge to return to IDLE).
- Address wrap: not applicable, since every ADDR_WIDTH value maps to a distinct block.

## Test plan
- After reset, read block 0 → `mem_busywait` rises the same cycle as `mem_read`; it falls after edge E0+5; `mem_readdata` = 128'h0.
- Write 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D to block 6'd37, drop the request in DONE, then read 37 → returns the same value; exactly 5 busy edges per transaction.
- Change `mem_address` to 6'd2 two cycles after accepting a write to 6'd9 → only block 9 updated; block 2 still reads 0.
- Assert read and write together on block 6'd5 with data 128'h1 → block 5 = 128'h1; `protocol_error` = 1 and stays 1 through later clean transactions.
- Assert reset during BUSY of a write of 128'hFF to block 6'd10 → busywait drops immediately, state is IDLE, and a subsequent read of block 10 returns 0.
- Hold `mem_read` through DONE into IDLE → a second read is accepted and busywait re-rises for LATENCY edges, demonstrating the re-issue behaviour.

Source files
------------

// File: rtl/block_data_memory.sv
// Block-granular backing store behind the data cache.
// Accepts one read-block or write-block request at a time and completes it
// LATENCY edges after acceptance. Completion is signalled by a one-cycle
// low pulse of mem_busywait (the DONE state), which the cache controller waits on.
module block_data_memory #(
    parameter int LATENCY     = 5,
    parameter int ADDR_WIDTH  = 6,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic [BLOCK_WIDTH-1:0] mem_writedata,
    output logic [BLOCK_WIDTH-1:0] mem_readdata,
    output logic                   mem_busywait,
    output logic                   protocol_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // The counter only ever holds values 0 .. LATENCY-1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
    logic                   opWrite_q, opWrite_d;
    logic                   protErr_q, protErr_d;
    logic [BLOCK_WIDTH-1:0] rdata_q, rdata_d;
    logic                   busyRaw;
    logic                   memWe;

    logic [BLOCK_WIDTH-1:0] memArray [DEPTH];

    // Next-state and output decode: request capture in IDLE, latency countdown
    // in BUSY, and the single completion cycle in DONE.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        opWrite_d = opWrite_q;
        protErr_d = protErr_q;
        rdata_d   = rdata_q;
        busyRaw   = 1'b0;
        memWe     = 1'b0;

        case (state_q)
            IDLE: begin
                // Busywait follows the request combinationally so the
                // requester sees it in the same cycle it raises the request.
                busyRaw = mem_read | mem_write;
                if (mem_read || mem_write) begin
                    addr_d    = mem_address;
                    wdata_d   = mem_writedata;
                    // A simultaneous read+write is serviced as a write and
                    // flagged; the flag is sticky until reset.
                    opWrite_d = mem_write;
                    if (mem_read && mem_write) begin
                        protErr_d = 1'b1;
                    end
                    count_d = CNT_LOAD;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                busyRaw = 1'b1;
                if (count_q != '0) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    if (opWrite_q) begin
                        memWe = 1'b1;
                    end else begin
                        rdata_d = memArray[addr_q];
                    end
                    state_d = DONE;
                end
            end

            DONE: begin
                // Requests are ignored here; a request still held when we are
                // back in IDLE starts a fresh transaction.
                busyRaw = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busyRaw = 1'b0;
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            opWrite_q <= 1'b0;
            protErr_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            opWrite_q <= opWrite_d;
            protErr_q <= protErr_d;
            rdata_q   <= rdata_d;
        end
    end

    // Block storage: cleared on reset, written only at write completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                memArray[i] <= '0;
            end
        end else if (memWe) begin
            memArray[addr_q] <= wdata_q;
        end
    end

    // Busywait is forced low while reset is held, whatever the requests do.
    assign mem_busywait   = reset ? 1'b0 : busyRaw;
    assign mem_readdata   = rdata_q;
    assign protocol_error = protErr_q;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed, table-driven bench for block_data_memory.
// Table rows are complete transactions with hand-computed results; the
// multi-cycle corner cases (input changes mid-flight, reset mid-flight,
// request held through DONE) are written out as explicit sequences.
module tb_block_data_memory;

    localparam int LATENCY = 5;
    localparam int MAX_EDGES = 20;

    logic         clock;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [5:0]   mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic         protocol_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic         rd;
        logic         wr;
        logic [5:0]   addr;
        logic [127:0] wdata;
        logic [127:0] expRdata;
        logic         expPerr;
    } vecT;

    localparam logic [127:0] PAT_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] PAT_B = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] PAT_X = 128'h99999999_88888888_77777777_66666666;
    localparam logic [127:0] PAT_Y = 128'h22222222_22222222_22222222_22222222;
    localparam logic [127:0] PAT_Z = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

    vecT vecs [7];

    block_data_memory #(
        .LATENCY    (LATENCY),
        .ADDR_WIDTH (6),
        .BLOCK_WIDTH(128)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .protocol_error(protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one value against its hand-computed expectation.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Count edges until busywait falls, bounded; leaves us #1 into DONE.
    task automatic waitDone(input string name, output int edges);
        edges = 0;
        while (edges < MAX_EDGES) begin
            @(posedge clock);
            #1;
            edges++;
            if (!mem_busywait) break;
        end
        checkOutput({name, "_busy_fell"}, 128'(mem_busywait), 128'd0);
    endtask

    // One full transaction from IDLE back to IDLE. If changeAt > 0 the
    // address and write data are altered that many edges after acceptance.
    task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                 input logic [5:0] addr, input logic [127:0] data,
                                 input int changeAt, input logic [5:0] altAddr,
                                 input logic [127:0] altData, output int edges);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = addr;
        mem_writedata = data;
        #1;
        checkOutput({name, "_busy_rise"}, 128'(mem_busywait), 128'd1);
        @(posedge clock);
        #1;
        edges = 0;
        while (edges < MAX_EDGES) begin
            @(posedge clock);
            #1;
            edges++;
            if (changeAt > 0 && edges == changeAt) begin
                mem_address   = altAddr;
                mem_writedata = altData;
            end
            if (!mem_busywait) break;
        end
        checkOutput({name, "_busy_fell"}, 128'(mem_busywait), 128'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clock);
        #1;
        checkOutput({name, "_idle_busy"}, 128'(mem_busywait), 128'd0);
    endtask

    task automatic readBlock(input string name, input logic [5:0] addr,
                             input logic [127:0] expData);
        int edges;
        applyStimulus(name, 1'b1, 1'b0, addr, '0, 0, '0, '0, edges);
        checkOutput({name, "_edges"}, 128'(edges), 128'(LATENCY));
        checkOutput({name, "_rdata"}, mem_readdata, expData);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int edges;

        vecs[0] = '{"rd0",   1'b1, 1'b0, 6'd0,  '0,    128'h0, 1'b0};
        vecs[1] = '{"wr37",  1'b0, 1'b1, 6'd37, PAT_A, 128'h0, 1'b0};
        vecs[2] = '{"rd37",  1'b1, 1'b0, 6'd37, '0,    PAT_A,  1'b0};
        vecs[3] = '{"wr63",  1'b0, 1'b1, 6'd63, PAT_B, PAT_A,  1'b0};
        vecs[4] = '{"rd63",  1'b1, 1'b0, 6'd63, '0,    PAT_B,  1'b0};
        vecs[5] = '{"rd1",   1'b1, 1'b0, 6'd1,  '0,    128'h0, 1'b0};
        vecs[6] = '{"rd37b", 1'b1, 1'b0, 6'd37, '0,    PAT_A,  1'b0};

        // Reset with a request asserted: busywait must stay low.
        reset         = 1'b1;
        mem_read      = 1'b1;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        #1;
        checkOutput("rst_busy", 128'(mem_busywait), 128'd0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_busy_held", 128'(mem_busywait), 128'd0);
        checkOutput("rst_rdata", mem_readdata, 128'h0);
        checkOutput("rst_perr", 128'(protocol_error), 128'd0);
        mem_read = 1'b0;
        reset    = 1'b0;
        @(posedge clock);
        #1;

        // Table of complete transactions.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                          vecs[i].wdata, 0, '0, '0, edges);
            checkOutput({vecs[i].name, "_edges"}, 128'(edges), 128'(LATENCY));
            checkOutput({vecs[i].name, "_rdata"}, mem_readdata, vecs[i].expRdata);
            checkOutput({vecs[i].name, "_perr"}, 128'(protocol_error), 128'(vecs[i].expPerr));
        end

        // Inputs changed two edges after acceptance must be ignored.
        applyStimulus("wr9", 1'b0, 1'b1, 6'd9, PAT_X, 2, 6'd2, PAT_Y, edges);
        checkOutput("wr9_edges", 128'(edges), 128'(LATENCY));
        readBlock("rd9", 6'd9, PAT_X);
        readBlock("rd2", 6'd2, 128'h0);

        // Read and write together: write wins, sticky error flag.
        applyStimulus("rw5", 1'b1, 1'b1, 6'd5, 128'h1, 0, '0, '0, edges);
        checkOutput("rw5_edges", 128'(edges), 128'(LATENCY));
        checkOutput("rw5_perr", 128'(protocol_error), 128'd1);
        checkOutput("rw5_rdata_kept", mem_readdata, 128'h0);
        readBlock("rd5", 6'd5, 128'h1);
        checkOutput("rd5_perr", 128'(protocol_error), 128'd1);
        applyStimulus("wr7", 1'b0, 1'b1, 6'd7, PAT_Y, 0, '0, '0, edges);
        checkOutput("wr7_perr", 128'(protocol_error), 128'd1);

        // Reset in the middle of a write aborts it.
        mem_write     = 1'b1;
        mem_address   = 6'd10;
        mem_writedata = 128'hFF;
        @(posedge clock);
        #1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("abort_busy_before", 128'(mem_busywait), 128'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 128'(mem_busywait), 128'd0);
        checkOutput("abort_rdata", mem_readdata, 128'h0);
        checkOutput("abort_perr", 128'(protocol_error), 128'd0);
        mem_write = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("abort_idle_busy", 128'(mem_busywait), 128'd0);
        readBlock("rd10", 6'd10, 128'h0);
        readBlock("rd37_cleared", 6'd37, 128'h0);

        // Read held through DONE is re-issued as a new transaction.
        applyStimulus("wr20", 1'b0, 1'b1, 6'd20, PAT_Z, 0, '0, '0, edges);
        mem_read    = 1'b1;
        mem_address = 6'd20;
        @(posedge clock);
        #1;
        waitDone("hold1", edges);
        checkOutput("hold1_edges", 128'(edges), 128'(LATENCY));
        checkOutput("hold1_rdata", mem_readdata, PAT_Z);
        @(posedge clock);
        #1;
        checkOutput("hold_rerise", 128'(mem_busywait), 128'd1);
        @(posedge clock);
        #1;
        waitDone("hold2", edges);
        checkOutput("hold2_edges", 128'(edges), 128'(LATENCY));
        mem_read = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("hold2_idle_busy", 128'(mem_busywait), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
